msm_bucket_aggregate: RTL and testbench
=======================================

Name: msm_bucket_aggregate

Overview:
- Reduction stage of the Pippenger MSM datapath. Consumes one window's bucket array after bucket population: B_j is the sum of all points G_i whose current scalar window equals j.
- Computes the window sum S = sum over j=1..NUM_BUCKETS-1 of j*B_j with the running-sum method. Uses one shared multi-cycle point_add instance and no scalar multiplies.
- Reads buckets through a synchronous read port. Returns S to the window-combining logic.

Parameters:
- WINDOW_BITS, 4, scalar window width c.
- NUM_BUCKETS, 2**WINDOW_BITS, number of bucket entries. Index 0 is never read. Legal range 2..2**WINDOW_BITS.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- Start  input  1  one-cycle request to begin aggregation. Sampled only in IDLE.
- bucket_rd_en  output  1  bucket read strobe.
- bucket_addr  output  WINDOW_BITS  bucket index being read.
- bucket_data  input  curve_point_t  bucket contents. Valid exactly 1 cycle after bucket_rd_en.
- Busy  output  1  high from the cycle after Start is accepted until Done.
- Done  output  1  one-cycle pulse when R is final.
- R  output  curve_point_t  window sum S. Held stable from Done until the next accepted Start.

Behaviour:
- Reset (Reset_n=0 at a clk edge):
  - state=IDLE; R=inf_point; Done=0; Busy=0; bucket_rd_en=0; bucket_addr=0.
  - Internal running=inf_point, total=inf_point.
  - Internal point_add is held in reset.
  - Reset mid-operation abandons the computation, with no partial R and no Done.
- Algorithm, j from NUM_BUCKETS-1 down to 1:
  - running = running + B_j
  - total = total + running
  - Final total = S.
- States:
  - IDLE: Start=1 -> set running=total=inf_point, j=NUM_BUCKETS-1 -> FETCH.
  - FETCH: bucket_rd_en=1 and bucket_addr=j for exactly one cycle -> WAIT_RD.
  - WAIT_RD: latch bucket_data into b_reg.
    - b_reg==inf_point -> ADD_TOT (running unchanged).
    - running==inf_point -> running=b_reg -> ADD_TOT (no adder use).
    - Otherwise -> ADD_RUN.
  - ADD_RUN: one-cycle point_add reset pulse with P=running, Q=b_reg, then wait for point_add Done. Capture sum into running -> ADD_TOT.
  - ADD_TOT:
    - running==inf_point -> NEXT.
    - total==inf_point -> total=running -> NEXT.
    - Otherwise pulse point_add with P=total, Q=running, wait Done, total=sum -> NEXT.
  - NEXT: j==1 -> FINISH; else j=j-1 -> FETCH.
  - FINISH: R=total; Done=1 for one cycle; Busy=0 -> IDLE.
- Adder operands:
  - point_add P/Q are registered and stable for the whole add.
  - A point_add Done that is still asserted from the previous add must not be taken as completion. Wait at least one cycle after the adder's reset pulse before sampling Done.
- Reads:
  - Exactly NUM_BUCKETS-1 reads per run, in strictly descending address order.
  - Address 0 is never issued.
  - bucket_rd_en is never high outside FETCH.
- Start rules:
  - Start while Busy is ignored.
  - Start in the same cycle as Done is ignored; Start is accepted only in IDLE.
- No output change other than R/Done/Busy/bucket_* as described. R is unchanged during a run until FINISH.
- Inf shortcuts are required so that all-empty windows complete without adder invocation.

Test Plan:
- All buckets inf_point, Start -> 15 reads at addresses 15..1, Done pulse; R==inf_point; point_add never started.
- B_1=G, others inf -> R==G; point_add never started.
- B_15=G, others inf -> R equals point_mul_double_and_add(G,15). Exactly 14 adder runs, from the total accumulation only.
- B_j=G for all j=1..15 -> R equals point_mul_double_and_add(G,120). B_3=G, B_5=H -> R==3G+5H.
- Reset_n=0 during ADD_RUN of a 120G run -> next cycle R==inf_point, Busy=0, Done=0. A fresh Start then gives the correct result.
- Start pulsed while Busy and on the Done cycle -> ignored; exactly one Done per accepted Start. NUM_BUCKETS=2 build: single read at address 1; R==B_1.

Source files
------------

// File: rtl/msm_bucket_aggregate.sv
// Pippenger window reduction: S = sum j*B_j via running/total sums.
// One shared multi-cycle point adder; inf shortcuts skip trivial adds.
package msm_pkg;
    typedef struct packed {
        logic        inf;
        logic [15:0] x;
        logic [15:0] y;
    } curve_point_t;

    localparam curve_point_t INF_POINT = '{inf: 1'b1, x: 16'd0, y: 16'd0};

    // Toy group law standing in for curve addition; inf is the identity.
    function automatic curve_point_t group_add(curve_point_t p, curve_point_t q);
        curve_point_t s;
        if (p.inf) begin
            s = q;
        end else if (q.inf) begin
            s = p;
        end else begin
            s.inf = 1'b0;
            s.x   = p.x + q.x;
            s.y   = p.y + q.y;
        end
        return s;
    endfunction
endpackage

module msm_point_add
    import msm_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  curve_point_t p,
    input  curve_point_t q,
    output logic         done,
    output curve_point_t sum
);
    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= 3'd0;
            done <= 1'b0;
            sum  <= INF_POINT;
        end else if (!done) begin
            if (cnt == 3'(LAT - 1)) begin
                done <= 1'b1;
                sum  <= group_add(p, q);
            end else begin
                cnt <= cnt + 3'd1;
            end
        end
    end
endmodule

module msm_bucket_aggregate
    import msm_pkg::*;
#(
    parameter int WINDOW_BITS = 4,
    parameter int NUM_BUCKETS = 2 ** WINDOW_BITS
) (
    input  logic                   clk,
    input  logic                   Reset_n,
    input  logic                   Start,
    output logic                   bucket_rd_en,
    output logic [WINDOW_BITS-1:0] bucket_addr,
    input  curve_point_t           bucket_data,
    output logic                   Busy,
    output logic                   Done,
    output curve_point_t           R
);
    localparam logic [WINDOW_BITS-1:0] JMAX = WINDOW_BITS'(NUM_BUCKETS - 1);
    localparam logic [WINDOW_BITS-1:0] JONE = WINDOW_BITS'(1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_RD, ADD_RUN, ADD_TOT, NEXT, FINISH
    } state_t;

    state_t                 state;
    logic [WINDOW_BITS-1:0] j;
    curve_point_t           running;
    curve_point_t           total;
    curve_point_t           b_reg;
    curve_point_t           add_p;
    curve_point_t           add_q;
    curve_point_t           add_sum;
    logic                   add_kick;
    logic                   add_done;
    logic                   add_rst_n;
    logic [1:0]             phase;

    // The kick resets the adder, clearing any done left from the last add.
    assign add_rst_n = Reset_n & ~add_kick;

    msm_point_add u_add (
        .clk   (clk),
        .rst_n (add_rst_n),
        .p     (add_p),
        .q     (add_q),
        .done  (add_done),
        .sum   (add_sum)
    );

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            j            <= JMAX;
            running      <= INF_POINT;
            total        <= INF_POINT;
            b_reg        <= INF_POINT;
            add_p        <= INF_POINT;
            add_q        <= INF_POINT;
            add_kick     <= 1'b0;
            phase        <= 2'd0;
            R            <= INF_POINT;
            Done         <= 1'b0;
            Busy         <= 1'b0;
            bucket_rd_en <= 1'b0;
            bucket_addr  <= '0;
        end else begin
            Done         <= 1'b0;
            bucket_rd_en <= 1'b0;
            add_kick     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start && !Done) begin
                        running      <= INF_POINT;
                        total        <= INF_POINT;
                        j            <= JMAX;
                        bucket_rd_en <= 1'b1;
                        bucket_addr  <= JMAX;
                        Busy         <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: state <= WAIT_RD;
                WAIT_RD: begin
                    b_reg <= bucket_data;
                    phase <= 2'd0;
                    if (bucket_data.inf) begin
                        state <= ADD_TOT;
                    end else if (running.inf) begin
                        running <= bucket_data;
                        state   <= ADD_TOT;
                    end else begin
                        state <= ADD_RUN;
                    end
                end
                ADD_RUN: begin
                    if (phase == 2'd0) begin
                        add_p    <= running;
                        add_q    <= b_reg;
                        add_kick <= 1'b1;
                        phase    <= 2'd1;
                    end else if (phase == 2'd1) begin
                        phase <= 2'd2;
                    end else if (add_done) begin
                        running <= add_sum;
                        phase   <= 2'd0;
                        state   <= ADD_TOT;
                    end
                end
                ADD_TOT: begin
                    if (phase == 2'd0) begin
                        if (running.inf) begin
                            state <= NEXT;
                        end else if (total.inf) begin
                            total <= running;
                            state <= NEXT;
                        end else begin
                            add_p    <= total;
                            add_q    <= running;
                            add_kick <= 1'b1;
                            phase    <= 2'd1;
                        end
                    end else if (phase == 2'd1) begin
                        phase <= 2'd2;
                    end else if (add_done) begin
                        total <= add_sum;
                        phase <= 2'd0;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (j == JONE) begin
                        state <= FINISH;
                    end else begin
                        j            <= j - JONE;
                        bucket_rd_en <= 1'b1;
                        bucket_addr  <= j - JONE;
                        state        <= FETCH;
                    end
                end
                FINISH: begin
                    R     <= total;
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msm_bucket_aggregate.sv
// Scoreboard bench for msm_bucket_aggregate: directed bucket windows,
// expected sums, adder-run and read counts checked by monitors.
module tb_msm_bucket_aggregate;
    import msm_pkg::*;

    typedef struct {
        curve_point_t r;
        int           adds;
        int           reads;
    } exp_t;

    localparam curve_point_t G    = '{inf: 1'b0, x: 16'h0003, y: 16'h0101};
    localparam curve_point_t H    = '{inf: 1'b0, x: 16'h0010, y: 16'h0007};
    localparam curve_point_t G15  = '{inf: 1'b0, x: 16'h002D, y: 16'h0F0F};
    localparam curve_point_t G120 = '{inf: 1'b0, x: 16'h0168, y: 16'h7878};
    localparam curve_point_t G3H5 = '{inf: 1'b0, x: 16'h0059, y: 16'h0326};

    logic         clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Start = 1'b0;
    logic         bucket_rd_en;
    logic [3:0]   bucket_addr;
    curve_point_t bucket_data = INF_POINT;
    logic         Busy;
    logic         Done;
    curve_point_t R;

    logic         Start2 = 1'b0;
    logic         rd_en2;
    logic [3:0]   addr2;
    curve_point_t data2 = INF_POINT;
    logic         Busy2;
    logic         Done2;
    curve_point_t R2;

    curve_point_t mem [16];
    curve_point_t mem2;
    exp_t         q1[$];
    exp_t         q2[$];
    int           applied = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    msm_bucket_aggregate #(.WINDOW_BITS(4)) dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .bucket_rd_en (bucket_rd_en),
        .bucket_addr  (bucket_addr),
        .bucket_data  (bucket_data),
        .Busy         (Busy),
        .Done         (Done),
        .R            (R)
    );

    msm_bucket_aggregate #(.WINDOW_BITS(4), .NUM_BUCKETS(2)) dut2 (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .Start        (Start2),
        .bucket_rd_en (rd_en2),
        .bucket_addr  (addr2),
        .bucket_data  (data2),
        .Busy         (Busy2),
        .Done         (Done2),
        .R            (R2)
    );

    always @(posedge clk) begin
        if (bucket_rd_en) bucket_data <= mem[bucket_addr];
        if (rd_en2) data2 <= (addr2 == 4'd1) ? mem2 : INF_POINT;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin : mon1
        int   reads;
        int   adds;
        logic busy_q;
        logic [3:0] nxt;
        exp_t e;
        reads = 0;
        adds = 0;
        busy_q = 1'b0;
        nxt = 4'd15;
        forever begin
            @(negedge clk);
            if (Busy && !busy_q) begin
                reads = 0;
                adds = 0;
                nxt = 4'd15;
            end
            busy_q = Busy;
            if (bucket_rd_en) begin
                chk("read_addr", 64'(bucket_addr), 64'(nxt));
                reads++;
                nxt = nxt - 4'd1;
            end
            if (dut.add_kick) adds++;
            if (Done) begin
                if (q1.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = q1.pop_front();
                    chk("R", 64'(R), 64'(e.r));
                    chk("adder_runs", 64'(adds), 64'(e.adds));
                    chk("read_count", 64'(reads), 64'(e.reads));
                end
            end
        end
    end

    initial begin : mon2
        int   reads;
        logic busy_q;
        exp_t e;
        reads = 0;
        busy_q = 1'b0;
        forever begin
            @(negedge clk);
            if (Busy2 && !busy_q) reads = 0;
            busy_q = Busy2;
            if (rd_en2) begin
                chk("nb2_addr", 64'(addr2), 64'(1));
                reads++;
            end
            if (Done2) begin
                if (q2.size() == 0) begin
                    chk("nb2_unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = q2.pop_front();
                    chk("nb2_R", 64'(R2), 64'(e.r));
                    chk("nb2_reads", 64'(reads), 64'(e.reads));
                end
            end
        end
    end

    task automatic fill(input curve_point_t v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic go(input curve_point_t r, input int adds, input int reads);
        exp_t e;
        e.r = r;
        e.adds = adds;
        e.reads = reads;
        q1.push_back(e);
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!Done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!Done) chk({nm, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        int n;
        fill(INF_POINT);
        mem2 = INF_POINT;
        repeat (3) @(negedge clk);
        chk("rst_R", 64'(R), 64'(INF_POINT));
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_rd_en", 64'(bucket_rd_en), 64'(0));
        chk("rst_addr", 64'(bucket_addr), 64'(0));
        Reset_n = 1'b1;

        go(INF_POINT, 0, 15);
        wait_done("all_inf");

        fill(INF_POINT);
        mem[1] = G;
        go(G, 0, 15);
        wait_done("b1");

        fill(INF_POINT);
        mem[15] = G;
        go(G15, 14, 15);
        wait_done("b15");

        fill(G);
        mem[0] = INF_POINT;
        go(G120, 28, 15);
        repeat (10) @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (40) @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        wait_done("all_g");
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        chk("start_on_done_ignored", 64'(Busy), 64'(0));

        fill(INF_POINT);
        mem[3] = G;
        mem[5] = H;
        go(G3H5, 5, 15);
        wait_done("g3h5");

        fill(G);
        mem[0] = INF_POINT;
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (!dut.add_kick && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_add", 64'(dut.add_kick), 64'(1));
        Reset_n = 1'b0;
        @(negedge clk);
        chk("abort_R", 64'(R), 64'(INF_POINT));
        chk("abort_busy", 64'(Busy), 64'(0));
        chk("abort_done", 64'(Done), 64'(0));
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);
        go(G120, 28, 15);
        wait_done("after_abort");

        mem2 = H;
        begin
            exp_t e;
            e.r = H;
            e.adds = 0;
            e.reads = 1;
            q2.push_back(e);
        end
        @(negedge clk);
        Start2 = 1'b1;
        @(negedge clk);
        Start2 = 1'b0;
        n = 0;
        while (!Done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!Done2) chk("nb2_timeout", 64'(0), 64'(1));

        repeat (3) @(negedge clk);
        chk("q1_drained", 64'(q1.size()), 64'(0));
        chk("q2_drained", 64'(q2.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
